// File: rtl/clock_set_ctrl.sv
// HH:MM:SS time-keeping and time-setting controller: BCD time registers advanced
// by a 1 Hz tick, button-driven edit FSM, and blink blanking of the edited field.
module clock_set_ctrl #(
    parameter int BLINK_CYCLES = 25000000,
    parameter int BLINK_W      = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [3:0] s_unit,
    output logic [3:0] s_ten,
    output logic [3:0] m_unit,
    output logic [3:0] m_ten,
    output logic [3:0] h_unit,
    output logic [3:0] h_ten,
    output logic [5:0] blank,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } state_t;

    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    state_t             state_q, state_d;
    logic [7:0]         sec_q, sec_d;
    logic [7:0]         min_q, min_d;
    logic [7:0]         hour_q, hour_d;
    logic [BLINK_W-1:0] cnt_q, cnt_d;
    logic               phase_q, phase_d;
    logic [5:0]         blank_q, blank_d;
    logic [2:0]         sync1_q, sync2_q, prev_q;
    logic [2:0]         press;
    logic               mode_press, inc_press, dec_press, adjust;

    // Two-digit BCD {ten,unit} step up/down with wrap at 'last' (8'h59 or 8'h23).
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] last);
        if (v == 8'h00)
            return last;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Bit order of the button vectors: [0]=mode, [1]=inc, [2]=dec.
    assign press      = sync2_q & ~prev_q;
    assign mode_press = press[0];
    assign inc_press  = press[1];
    assign dec_press  = press[2];
    assign adjust     = (state_q != ST_RUN) && !mode_press && (inc_press ^ dec_press);

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        blank_d = 6'b000000;

        if (mode_press) begin
            case (state_q)
                ST_RUN:   state_d = ST_SET_H;
                ST_SET_H: state_d = ST_SET_M;
                ST_SET_M: state_d = ST_SET_S;
                default:  state_d = ST_RUN;
            endcase
        end

        // Ticks are honoured on the RUN cycle even if a mode press lands with them.
        case (state_q)
            ST_RUN: begin
                if (tick) begin
                    sec_d = bcd_inc(sec_q, 8'h59);
                    if (sec_q == 8'h59) begin
                        min_d = bcd_inc(min_q, 8'h59);
                        if (min_q == 8'h59)
                            hour_d = bcd_inc(hour_q, 8'h23);
                    end
                end
            end
            ST_SET_H: if (adjust) hour_d = inc_press ? bcd_inc(hour_q, 8'h23) : bcd_dec(hour_q, 8'h23);
            ST_SET_M: if (adjust) min_d  = inc_press ? bcd_inc(min_q, 8'h59)  : bcd_dec(min_q, 8'h59);
            ST_SET_S: if (adjust) sec_d  = inc_press ? bcd_inc(sec_q, 8'h59)  : bcd_dec(sec_q, 8'h59);
            default: ;
        endcase

        if (mode_press || adjust) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == BLINK_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Blanking follows the next state so mode and blank always change together.
        case (state_d)
            ST_SET_H: blank_d = {phase_d, phase_d, 4'b0000};
            ST_SET_M: blank_d = {2'b00, phase_d, phase_d, 2'b00};
            ST_SET_S: blank_d = {4'b0000, phase_d, phase_d};
            default:  blank_d = 6'b000000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            sec_q   <= 8'h00;
            min_q   <= 8'h00;
            hour_q  <= 8'h00;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            blank_q <= 6'b000000;
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            prev_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            blank_q <= blank_d;
            sync1_q <= {btn_dec, btn_inc, btn_mode};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign s_unit = sec_q[3:0];
    assign s_ten  = sec_q[7:4];
    assign m_unit = min_q[3:0];
    assign m_ten  = min_q[7:4];
    assign h_unit = hour_q[3:0];
    assign h_ten  = hour_q[7:4];
    assign blank  = blank_q;
    assign mode   = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: table of button/tick operations with a
// scoreboard of expected time/mode/blank, plus hand-written blink, hold and reset cases.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [3:0] s_unit, s_ten, m_unit, m_ten, h_unit, h_ten;
    logic [5:0] blank;
    logic [1:0] mode;

    int errors = 0;
    int checks = 0;

    clock_set_ctrl #(.BLINK_CYCLES(4), .BLINK_W(3)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .s_unit(s_unit), .s_ten(s_ten), .m_unit(m_unit), .m_ten(m_ten),
        .h_unit(h_unit), .h_ten(h_ten), .blank(blank), .mode(mode)
    );

    always #5 clk = ~clk;

    typedef enum int {OP_TICKS, OP_MODE, OP_INC, OP_DEC, OP_INCDEC, OP_MODEINC} op_e;

    typedef struct {
        op_e         op;
        int          n;
        logic [23:0] t;
        logic [1:0]  m;
        logic        chk_b;
        logic [5:0]  b;
    } vec_t;

    typedef struct {
        string       name;
        logic [23:0] t;
        logic [1:0]  m;
        logic        chk_b;
        logic [5:0]  b;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[19];

    function automatic logic [23:0] cur_time();
        return {h_ten, h_unit, m_ten, m_unit, s_ten, s_unit};
    endfunction

    task automatic push_exp(input string name, input logic [23:0] t, input logic [1:0] m,
                            input logic chk_b, input logic [5:0] b);
        exp_t e;
        e.name = name; e.t = t; e.m = m; e.chk_b = chk_b; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = exp_q.pop_front();
        if (cur_time() !== e.t || mode !== e.m || (e.chk_b && blank !== e.b)) begin
            errors++;
            $display("FAIL %s: got time=%h mode=%0d blank=%b, want time=%h mode=%0d blank=%b%s",
                     e.name, cur_time(), mode, blank, e.t, e.m, e.b, e.chk_b ? "" : " (blank unchecked)");
        end else begin
            $display("ok   %s: time=%h mode=%0d blank=%b", e.name, cur_time(), mode, blank);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Button ops leave the bench 1 time unit after the edge that applies the action.
    task automatic do_op(input op_e op, input int n);
        if (op == OP_TICKS) begin
            for (int k = 0; k < n; k++) begin
                @(posedge clk); #1 tick = 1'b1;
                @(posedge clk); #1 tick = 1'b0;
            end
        end else begin
            @(posedge clk); #1;
            btn_mode = (op == OP_MODE) || (op == OP_MODEINC);
            btn_inc  = (op == OP_INC) || (op == OP_INCDEC) || (op == OP_MODEINC);
            btn_dec  = (op == OP_DEC) || (op == OP_INCDEC);
            repeat (3) @(posedge clk);
            #1;
            btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        end
    endtask

    task automatic press_n(input op_e op, input int n);
        for (int k = 0; k < n; k++) begin
            do_op(op, 1);
            idle(2);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{OP_TICKS,   3661, 24'h010101, 2'd0, 1'b1, 6'd0};
        vecs[1]  = '{OP_MODE,    1, 24'h010101, 2'd1, 1'b1, 6'd0};
        vecs[2]  = '{OP_DEC,     1, 24'h000101, 2'd1, 1'b1, 6'd0};
        vecs[3]  = '{OP_DEC,     1, 24'h230101, 2'd1, 1'b1, 6'd0};
        vecs[4]  = '{OP_MODE,    1, 24'h230101, 2'd2, 1'b1, 6'd0};
        vecs[5]  = '{OP_DEC,     1, 24'h230001, 2'd2, 1'b1, 6'd0};
        vecs[6]  = '{OP_DEC,     1, 24'h235901, 2'd2, 1'b1, 6'd0};
        vecs[7]  = '{OP_MODE,    1, 24'h235901, 2'd3, 1'b1, 6'd0};
        vecs[8]  = '{OP_DEC,     1, 24'h235900, 2'd3, 1'b1, 6'd0};
        vecs[9]  = '{OP_DEC,     1, 24'h235959, 2'd3, 1'b1, 6'd0};
        vecs[10] = '{OP_MODE,    1, 24'h235959, 2'd0, 1'b1, 6'd0};
        vecs[11] = '{OP_TICKS,   1, 24'h000000, 2'd0, 1'b1, 6'd0};
        vecs[12] = '{OP_INC,     1, 24'h000000, 2'd0, 1'b1, 6'd0};
        vecs[13] = '{OP_MODE,    1, 24'h000000, 2'd1, 1'b1, 6'd0};
        vecs[14] = '{OP_DEC,     1, 24'h230000, 2'd1, 1'b1, 6'd0};
        vecs[15] = '{OP_INC,     1, 24'h000000, 2'd1, 1'b1, 6'd0};
        vecs[16] = '{OP_INCDEC,  1, 24'h000000, 2'd1, 1'b0, 6'd0};
        vecs[17] = '{OP_TICKS,   5, 24'h000000, 2'd1, 1'b0, 6'd0};
        vecs[18] = '{OP_MODEINC, 1, 24'h000000, 2'd2, 1'b1, 6'd0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        push_exp("reset", 24'h000000, 2'd0, 1'b1, 6'd0);
        @(negedge clk); compare();

        for (int v = 0; v < 19; v++) begin
            push_exp($sformatf("vec%0d", v), vecs[v].t, vecs[v].m, vecs[v].chk_b, vecs[v].b);
            do_op(vecs[v].op, vecs[v].n);
            @(negedge clk); compare();
            idle(2);
        end

        // Blink in SET_M: an applied inc clears phase, then 4 cycles visible, 4 blanked.
        push_exp("blink_inc1", 24'h000100, 2'd2, 1'b1, 6'd0);
        do_op(OP_INC, 1);
        @(negedge clk); compare();
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            push_exp($sformatf("blink_k%0d", k), 24'h000100, 2'd2, 1'b1,
                     ((k / 4) % 2) ? 6'b001100 : 6'b000000);
            @(negedge clk); compare();
        end
        push_exp("blink_inc2", 24'h000200, 2'd2, 1'b1, 6'd0);
        do_op(OP_INC, 1);
        @(negedge clk); compare();
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            push_exp($sformatf("blink_after_k%0d", k), 24'h000200, 2'd2, 1'b1,
                     (k == 4) ? 6'b001100 : 6'b000000);
            @(negedge clk); compare();
        end
        idle(2);

        // Held inc: action on exactly the third edge after the raw rise, then nothing.
        @(posedge clk); #1 btn_inc = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            push_exp($sformatf("hold_edge%0d", c), (c < 3) ? 24'h000200 : 24'h000300, 2'd2, 1'b0, 6'd0);
            @(negedge clk); compare();
        end
        repeat (97) @(posedge clk);
        push_exp("hold_100", 24'h000300, 2'd2, 1'b0, 6'd0);
        @(negedge clk); compare();
        @(posedge clk); #1 btn_inc = 1'b0;
        idle(3);

        // Build 12:34:56 in SET_M, then reset mid-edit.
        press_n(OP_INC, 31);
        press_n(OP_MODE, 1);
        press_n(OP_DEC, 4);
        press_n(OP_MODE, 2);
        press_n(OP_INC, 12);
        press_n(OP_MODE, 1);
        push_exp("preset_123456", 24'h123456, 2'd2, 1'b0, 6'd0);
        @(negedge clk); compare();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        push_exp("reset_mid_edit", 24'h000000, 2'd0, 1'b1, 6'd0);
        @(negedge clk); compare();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-keeping and time-setting controller for the six-digit HH:MM:SS display.
- Owns the BCD time registers and advances them on a 1 Hz tick.
- Runs a button-driven state machine that lets the user freeze the clock and adjust hours, minutes or seconds.
- Drives per-digit blanking so the field being edited blinks.
- Sits between the clock divider (tick source) and the bcd7seg digit decoders.

Parameters:
BLINK_CYCLES, 25000000, clk cycles per blink half-period; must be >= 2.
BLINK_W, 25, width of the blink cycle counter; must satisfy 2^BLINK_W > BLINK_CYCLES.

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
tick  input  1  one-clk-wide 1 Hz pulse from the divider
btn_mode  input  1  raw mode button, asynchronous level, active-high
btn_inc  input  1  raw increment button, asynchronous level, active-high
btn_dec  input  1  raw decrement button, asynchronous level, active-high
s_unit  output  4  seconds units, BCD 0-9
s_ten  output  4  seconds tens, BCD 0-5
m_unit  output  4  minutes units, BCD 0-9
m_ten  output  4  minutes tens, BCD 0-5
h_unit  output  4  hours units, BCD 0-9 (0-3 when h_ten=2)
h_ten  output  4  hours tens, BCD 0-2
blank  output  6  per-digit blank, 1 = digit off; [0]=s_unit, [1]=s_ten, [2]=m_unit, [3]=m_ten, [4]=h_unit, [5]=h_ten
mode  output  2  current state: 0=RUN, 1=SET_H, 2=SET_M, 3=SET_S

Behaviour:
Reset (synchronous, checked every cycle, overrides all other inputs):
- Time = 00:00:00, mode = RUN, blank = 0.
- Synchronizer and edge flops = 0, blink counter = 0, blink phase = 0.

Button path:
- Each button passes through a 2-flop synchronizer, then a rising-edge detector.
- A "press" is a one-cycle pulse.
- The action is visible on the outputs 3 clk cycles after the raw input rises.
- Holding a button produces exactly one press; no auto-repeat. No debounce is performed here.

State machine:
- Each mode press advances RUN -> SET_H -> SET_M -> SET_S -> RUN.
- The new state is visible the cycle after the press.

RUN:
- A tick increments seconds, carrying into minutes and hours.
- Ranges: seconds 00-59, minutes 00-59, hours 00-23.
- 23:59:59 plus a tick gives 00:00:00.
- Outputs update the cycle after tick is high.
- inc and dec presses are ignored.

SET_x (time frozen, tick ignored):
- An inc press adds 1 to the selected field, modulo (24 for hours, 60 for minutes and seconds).
- A dec press subtracts 1 with wrap: hours 00 -> 23, minutes and seconds 00 -> 59.
- No carry or borrow into other fields.
- inc and dec pressed in the same cycle: no change.

Simultaneous events:
- A mode press in the same cycle as inc or dec: the mode advance takes effect and inc/dec are dropped.
- A tick in the same cycle as a RUN -> SET_H mode press is applied, because the state is still RUN that cycle.
- Leaving SET_S returns to RUN with no tick credit; counting resumes at the next tick.

Arithmetic:
- Stored as BCD digits; no binary conversion.
- All outputs hold valid BCD at all times.
- Hours never exceed 23.

Blink:
- The blink counter counts 0..BLINK_CYCLES-1, then wraps and toggles the phase.
- On any mode press, or any applied inc/dec, the counter and phase clear to 0 (digits visible).
- In RUN: blank = 6'b000000.
- In SET_H: blank = {phase, phase, 4'b0}.
- In SET_M: blank = {2'b0, phase, phase, 2'b0}.
- In SET_S: blank = {4'b0, phase, phase}.

Output registers:
- All outputs are registered.
- Reset in any state, including mid-edit, returns immediately to RUN at 00:00:00.

Test Plan:
1. Reset, then 3661 tick pulses in RUN -> time 01:01:01, blank=0, mode=0.
2. Preload 23:59:59 via SET presses; return to RUN; one tick -> 00:00:00 on the following cycle.
3. Mode press once (mode=1); dec at 00 -> h=23; inc -> h=00; inc and dec in the same cycle -> unchanged; 5 ticks meanwhile -> seconds unchanged.
4. BLINK_CYCLES=4, SET_M: blank toggles between 6'b000000 and 6'b001100 every 4 cycles; an inc press resets the phase to visible.
5. Mode press and inc press on the same cycle in SET_H -> mode=2, hours unchanged; raw button held 100 cycles -> exactly one action, 3 cycles after the raw rise.
6. Assert reset while in SET_M at 12:34:56 -> next cycle 00:00:00, mode=0, blank=0.
